// File: rtl/user_uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a parametrised byte FIFO on a naive_bus slave port.
// Register map: DATA 0x0 (push / fifo_len), CTRL 0x4 (divisor, framing, enable, flush), STATUS 0x8.
module user_uart_tx_cfg #(
  parameter int unsigned FIFO_AW         = 8,
  parameter int unsigned DEFAULT_CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  output logic        rd_gnt,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  output logic        wr_gnt,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        o_uart_tx
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FullLen = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StParity, StStop} state_e;

  logic [15:0]      clk_div_q;
  logic             par_en_q, par_odd_q, stop2_q, tx_en_q;
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q, fifo_len;
  logic [7:0]       mem [Depth];
  logic [7:0]       ram_rd_q;
  logic             full, empty, push, pop, flush, ctrl_wr;
  logic             wr_dec, rd_dec;
  logic [31:0]      rd_val;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_q, bit_d;
  logic        par_q, par_d, fr_par_en_q, fr_par_en_d, fr_stop2_q, fr_stop2_d;
  logic        stop_cnt_q, stop_cnt_d, bit_end;

  assign fifo_len = wr_ptr_q - rd_ptr_q;
  assign full     = (fifo_len == FullLen);
  assign empty    = (fifo_len == '0);

  assign wr_dec  = (wr_addr[31:4] == 28'd0);
  assign rd_dec  = (rd_addr[31:4] == 28'd0);
  // Only a byte push into a full FIFO stalls; everything else is granted at once.
  assign wr_gnt  = wr_req & ~(wr_dec & (wr_addr[3:2] == 2'd0) & wr_be[0] & full);
  assign push    = wr_gnt & wr_dec & (wr_addr[3:2] == 2'd0) & wr_be[0];
  assign ctrl_wr = wr_gnt & wr_dec & (wr_addr[3:2] == 2'd1);
  assign flush   = ctrl_wr & wr_be[2] & wr_data[20];
  assign pop     = (state_q == StLoad);
  assign rd_gnt  = rd_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      // Flush takes the pre-push write pointer so a same-cycle push survives.
      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data[7:0];
    ram_rd_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_div_q <= 16'(DEFAULT_CLK_DIV);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_en_q   <= 1'b1;
    end else if (ctrl_wr) begin
      if (wr_be[0]) clk_div_q[7:0]  <= wr_data[7:0];
      if (wr_be[1]) clk_div_q[15:8] <= wr_data[15:8];
      if (wr_be[2]) begin
        par_en_q  <= wr_data[16];
        par_odd_q <= wr_data[17];
        stop2_q   <= wr_data[18];
        tx_en_q   <= wr_data[19];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_dec) begin
      unique case (rd_addr[3:2])
        2'd0: rd_val[FIFO_AW:0] = fifo_len;
        2'd1: rd_val = {12'd0, tx_en_q, stop2_q, par_odd_q, par_en_q, clk_div_q};
        2'd2: begin
          rd_val[FIFO_AW:0] = fifo_len;
          rd_val[24]        = full;
          rd_val[25]        = empty;
          rd_val[26]        = (state_q != StIdle);
        end
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_req ? rd_val : 32'd0;
  end

  assign bit_end = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    par_d       = par_q;
    fr_par_en_d = fr_par_en_q;
    fr_stop2_d  = fr_stop2_q;
    stop_cnt_d  = stop_cnt_q;
    o_uart_tx   = 1'b1;
    if (state_q != StIdle && state_q != StLoad) cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    unique case (state_q)
      StIdle: if (tx_en_q && !empty && !flush) state_d = StLoad;
      StLoad: begin
        // Frame config is frozen here; later CTRL writes only affect the next frame.
        shreg_d     = ram_rd_q;
        div_d       = (clk_div_q < 16'd4) ? 16'd4 : clk_div_q;
        par_d       = (^ram_rd_q) ^ par_odd_q;
        fr_par_en_d = par_en_q;
        fr_stop2_d  = stop2_q;
        cnt_d       = '0;
        bit_d       = '0;
        stop_cnt_d  = 1'b0;
        state_d     = StStart;
      end
      StStart: begin
        o_uart_tx = 1'b0;
        if (bit_end) state_d = StData;
      end
      StData: begin
        o_uart_tx = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = fr_par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        o_uart_tx = par_q;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (fr_stop2_q && !stop_cnt_q) stop_cnt_d = 1'b1;
          else                           state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= 16'd4;
      shreg_q     <= '0;
      bit_q       <= '0;
      par_q       <= 1'b0;
      fr_par_en_q <= 1'b0;
      fr_stop2_q  <= 1'b0;
      stop_cnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      par_q       <= par_d;
      fr_par_en_q <= fr_par_en_d;
      fr_stop2_q  <= fr_stop2_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{rd_addr[1:0], wr_addr[1:0], wr_data[31:21], wr_be[3]};

endmodule
